// File: rtl/line_fill_unit_if.sv
// Word-wide memory beat bus between the line fill unit (master) and main memory (slave).
// One request is in flight at a time; read data returns later on mem_rvalid.
interface line_fill_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/line_fill_unit.sv
// Cache line transfer engine: optional victim write-back as 32-bit beats, then a
// beat-by-beat line fetch that is committed to the data array in one full-mask write.
module line_fill_unit #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fill_req,
    input  logic                        wb_req,
    input  logic [S_INDEX-1:0]          req_index,
    input  logic [31-S_OFFSET:0]        fill_addr,
    input  logic [31-S_OFFSET:0]        wb_addr,
    input  logic [8*(2**S_OFFSET)-1:0]  wb_line,
    output logic                        busy,
    output logic                        done,
    line_fill_unit_if.master            mem,
    output logic [2**S_OFFSET-1:0]      arr_write_en,
    output logic [S_INDEX-1:0]          arr_windex,
    output logic [8*(2**S_OFFSET)-1:0]  arr_datain
);
    localparam int LINE_W = 8 * (2 ** S_OFFSET);
    localparam int BEATS  = 2 ** (S_OFFSET - 2);
    // Counter is kept at least one bit wide so a single-beat line still elaborates.
    localparam int CW     = (S_OFFSET > 2) ? S_OFFSET - 2 : 1;
    localparam int NW     = 2 ** CW;
    localparam int AW     = 32 - S_OFFSET;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL_REQ,
        FILL_WAIT,
        COMMIT,
        DONE
    } state_t;

    state_t              state_reg;
    logic [CW-1:0]       beat_reg;
    logic                fill_flag_reg;
    logic [S_INDEX-1:0]  index_reg;
    logic [AW-1:0]       fill_addr_reg;
    logic [AW-1:0]       wb_addr_reg;
    logic [LINE_W-1:0]   wb_line_reg;
    logic [NW-1:0][31:0] wb_word;
    logic [S_OFFSET-1:0] beat_off;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            beat_reg      <= '0;
            fill_flag_reg <= 1'b0;
            index_reg     <= '0;
            fill_addr_reg <= '0;
            wb_addr_reg   <= '0;
            wb_line_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fill_req || wb_req) begin
                        fill_flag_reg <= fill_req;
                        index_reg     <= req_index;
                        fill_addr_reg <= fill_addr;
                        wb_addr_reg   <= wb_addr;
                        wb_line_reg   <= wb_line;
                        beat_reg      <= '0;
                        state_reg     <= wb_req ? WB : FILL_REQ;
                    end
                end
                WB: begin
                    if (mem.mem_ready) begin
                        if (beat_reg == LAST) begin
                            beat_reg  <= '0;
                            state_reg <= fill_flag_reg ? FILL_REQ : DONE;
                        end else begin
                            beat_reg <= beat_reg + CW'(1);
                        end
                    end
                end
                FILL_REQ: begin
                    if (mem.mem_ready) begin
                        state_reg <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    // Only one read is ever outstanding, so rvalid always answers beat_reg.
                    if (mem.mem_rvalid) begin
                        beat_reg  <= beat_reg + CW'(1);
                        state_reg <= (beat_reg == LAST) ? COMMIT : FILL_REQ;
                    end
                end
                COMMIT:  state_reg <= DONE;
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_word
            if (gi < BEATS) begin : g_live
                logic [31:0] word_reg;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        word_reg <= '0;
                    end else if (state_reg == FILL_WAIT && mem.mem_rvalid && beat_reg == CW'(gi)) begin
                        word_reg <= mem.mem_rdata;
                    end
                end

                assign arr_datain[32*gi +: 32] = word_reg;
                assign wb_word[gi]             = wb_line_reg[32*gi +: 32];
            end else begin : g_pad
                assign wb_word[gi] = '0;
            end
        end

        if (S_OFFSET > 2) begin : g_off
            assign beat_off = {beat_reg, 2'b00};
        end else begin : g_off_single
            assign beat_off = '0;
        end
    endgenerate

    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign arr_write_en = (state_reg == COMMIT) ? '1 : '0;
    assign arr_windex   = (state_reg == COMMIT) ? index_reg : '0;

    // Bus outputs decode only registered state, so stalls hold them steady.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state_reg)
            WB: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {wb_addr_reg, beat_off};
                mem.mem_wdata = wb_word[beat_reg];
            end
            FILL_REQ: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = {fill_addr_reg, beat_off};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_line_fill_unit.sv
// Scoreboard bench for line_fill_unit: stimulus queues expected beats, commits and
// done pulses; a monitor pops and compares them as the unit presents each one.
module tb_line_fill_unit;
    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int LINE_W   = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                fill_req;
    logic                wb_req;
    logic [2:0]          req_index;
    logic [26:0]         fill_addr;
    logic [26:0]         wb_addr;
    logic [LINE_W-1:0]   wb_line;
    logic                busy;
    logic                done;
    logic [31:0]         arr_write_en;
    logic [2:0]          arr_windex;
    logic [LINE_W-1:0]   arr_datain;

    line_fill_unit_if mem();

    line_fill_unit #(.S_OFFSET(S_OFFSET), .S_INDEX(S_INDEX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fill_req     (fill_req),
        .wb_req       (wb_req),
        .req_index    (req_index),
        .fill_addr    (fill_addr),
        .wb_addr      (wb_addr),
        .wb_line      (wb_line),
        .busy         (busy),
        .done         (done),
        .mem          (mem),
        .arr_write_en (arr_write_en),
        .arr_windex   (arr_windex),
        .arr_datain   (arr_datain)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [2:0]        idx;
        logic [LINE_W-1:0] line;
        int                cyc;
    } commit_t;

    beat_t   exp_beats[$];
    commit_t exp_commits[$];
    int      exp_done[$];

    int n_checks   = 0;
    int n_err      = 0;
    int cyc        = 0;
    int rd_acc_cnt = 0;
    bit mon_en     = 1'b0;
    bit stall      = 1'b0;
    bit spur       = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [31:0] val);
        n_checks++;
        n_err++;
        $display("FAIL %s: got %0h with nothing expected", name, val);
    endtask

    function automatic logic [LINE_W-1:0] line_of(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    // Memory contents: 0x1000 + word-in-line + (line address low nibble << 8).
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return 32'h1000 + {29'h0, a[4:2]} + {20'h0, a[8:5], 8'h0};
    endfunction

    task automatic push_wb(input logic [26:0] wa, input logic [31:0] base);
        beat_t e;
        for (int k = 0; k < 8; k++) begin
            e.we   = 1'b1;
            e.addr = {wa, 3'(k), 2'b00};
            e.data = base + 32'(k);
            exp_beats.push_back(e);
        end
    endtask

    task automatic push_fill(input logic [26:0] fa, input logic [2:0] idx,
                             input logic [31:0] base, input int t_commit);
        beat_t   e;
        commit_t c;
        for (int k = 0; k < 8; k++) begin
            e.we   = 1'b0;
            e.addr = {fa, 3'(k), 2'b00};
            e.data = '0;
            exp_beats.push_back(e);
        end
        c.idx  = idx;
        c.line = line_of(base);
        c.cyc  = t_commit;
        exp_commits.push_back(c);
        exp_done.push_back((t_commit < 0) ? -1 : t_commit + 1);
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", LINE_W'(seen), LINE_W'(1));
    endtask

    // Memory responder: ready is 1 or toggling; read data returns 0..3 cycles after acceptance.
    logic        acc_rd;
    logic [31:0] acc_addr;
    logic [31:0] pend_data;
    bit          pend;
    int          wait_cnt;
    int          dly_seq;
    initial begin
        mem.mem_ready  = 1'b1;
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = 32'h0BAD_0000;
        pend = 1'b0; wait_cnt = 0; dly_seq = 0;
        forever begin
            @(negedge clk);
            acc_rd   = mem.mem_req && mem.mem_ready && !mem.mem_we && rst_n;
            acc_addr = mem.mem_addr;
            @(posedge clk);
            #1;
            mem.mem_rvalid = 1'b0;
            mem.mem_rdata  = 32'h0BAD_0000;
            if (acc_rd) begin
                pend      = 1'b1;
                pend_data = mem_model(acc_addr);
                wait_cnt  = stall ? dly_seq : 0;
                dly_seq   = (dly_seq + 1) % 4;
            end
            if (pend) begin
                if (wait_cnt == 0) begin
                    mem.mem_rvalid = 1'b1;
                    mem.mem_rdata  = pend_data;
                    pend = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (spur) begin
                mem.mem_rvalid = 1'b1;
                mem.mem_rdata  = 32'hDEAD_BEEF;
            end
            mem.mem_ready = stall ? !mem.mem_ready : 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever the unit presents a beat, commit or done.
    beat_t       mb;
    commit_t     mc;
    int          md;
    bit          stalled_prev = 1'b0;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stalled_prev) begin
                    check("stall_req", LINE_W'(mem.mem_req), LINE_W'(1));
                    check("stall_addr", LINE_W'(mem.mem_addr), LINE_W'(st_addr));
                    check("stall_wdata", LINE_W'(mem.mem_wdata), LINE_W'(st_wdata));
                end
                stalled_prev = mem.mem_req && !mem.mem_ready;
                st_addr      = mem.mem_addr;
                st_wdata     = mem.mem_wdata;
                if (mem.mem_req && mem.mem_ready) begin
                    if (exp_beats.size() == 0) begin
                        fail_unexpected("unexpected_beat", mem.mem_addr);
                    end else begin
                        mb = exp_beats.pop_front();
                        check("beat_we", LINE_W'(mem.mem_we), LINE_W'(mb.we));
                        check("beat_addr", LINE_W'(mem.mem_addr), LINE_W'(mb.addr));
                        if (mb.we) check("beat_wdata", LINE_W'(mem.mem_wdata), LINE_W'(mb.data));
                        else rd_acc_cnt++;
                    end
                end
                if (arr_write_en !== 32'h0) begin
                    if (exp_commits.size() == 0) begin
                        fail_unexpected("unexpected_commit", arr_write_en);
                    end else begin
                        mc = exp_commits.pop_front();
                        check("commit_mask", LINE_W'(arr_write_en), LINE_W'(32'hFFFF_FFFF));
                        check("commit_index", LINE_W'(arr_windex), LINE_W'(mc.idx));
                        check("commit_line", arr_datain, mc.line);
                        if (mc.cyc >= 0) check("commit_cycle", LINE_W'(cyc), LINE_W'(mc.cyc));
                    end
                end
                if (done === 1'b1) begin
                    if (exp_done.size() == 0) begin
                        fail_unexpected("unexpected_done", 32'(cyc));
                    end else begin
                        md = exp_done.pop_front();
                        if (md >= 0) check("done_cycle", LINE_W'(cyc), LINE_W'(md));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; fill_req = 1'b1; wb_req = 1'b0; req_index = 3'd5;
        fill_addr = 27'h40; wb_addr = '0; wb_line = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", LINE_W'(busy), '0);
        check("rst_done", LINE_W'(done), '0);
        check("rst_mem_req", LINE_W'(mem.mem_req), '0);
        check("rst_mem_we", LINE_W'(mem.mem_we), '0);
        check("rst_mem_addr", LINE_W'(mem.mem_addr), '0);
        check("rst_mem_wdata", LINE_W'(mem.mem_wdata), '0);
        check("rst_write_en", LINE_W'(arr_write_en), '0);
        check("rst_windex", LINE_W'(arr_windex), '0);
        check("rst_datain", arr_datain, '0);
        mon_en = 1'b1;
        $display("txn fill-only after reset release: addr 0x40 index 5");
        push_fill(27'h40, 3'd5, 32'h1000, cyc + 17);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_req = 1'b0;
        check("busy_after_accept", LINE_W'(busy), LINE_W'(1));
        wait_done(40);

        $display("txn back-to-back fill: addr 0x41 index 6");
        fill_addr = 27'h41; req_index = 3'd6; fill_req = 1'b1;
        push_fill(27'h41, 3'd6, 32'h1100, cyc + 1 + 17);
        @(posedge clk); @(posedge clk); #1;
        fill_req = 1'b0;
        wait_done(40);
        @(posedge clk); #1;

        $display("txn evict-then-fill: wb 0x1 fill 0x42 index 3");
        wb_addr = 27'h1; wb_line = line_of(32'hA0); fill_addr = 27'h42; req_index = 3'd3;
        push_wb(27'h1, 32'hA0);
        push_fill(27'h42, 3'd3, 32'h1200, cyc + 25);
        wb_req = 1'b1; fill_req = 1'b1;
        @(posedge clk); #1;
        wb_req = 1'b0; fill_req = 1'b0;
        wait_done(60);
        @(posedge clk); #1;

        $display("txn write-back only with spurious rvalid and ignored fill_req");
        wb_addr = 27'h2; wb_line = line_of(32'hB0); fill_addr = 27'h55; req_index = 3'd1;
        push_wb(27'h2, 32'hB0);
        exp_done.push_back(cyc + 9);
        wb_req = 1'b1;
        @(posedge clk); #1;
        wb_req = 1'b0;
        @(posedge clk); #2;
        spur = 1'b1; fill_req = 1'b1;
        @(posedge clk); #2;
        spur = 1'b0; fill_req = 1'b0;
        wait_done(40);
        @(posedge clk); #2;
        spur = 1'b1;
        @(posedge clk); #2;
        spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("datain_after_spurious", arr_datain, line_of(32'h1200));

        $display("txn stalled evict-then-fill: wb 0x3 fill 0x40 index 2");
        stall = 1'b1;
        wb_addr = 27'h3; wb_line = line_of(32'hC0); fill_addr = 27'h40; req_index = 3'd2;
        push_wb(27'h3, 32'hC0);
        push_fill(27'h40, 3'd2, 32'h1000, -1);
        wb_req = 1'b1; fill_req = 1'b1;
        @(posedge clk); #1;
        wb_req = 1'b0; fill_req = 1'b0;
        wait_done(200);
        @(posedge clk); #2;
        stall = 1'b0;
        @(posedge clk); #1;

        $display("txn fill 0x43 index 7 with reset after four beats");
        begin
            int base;
            base = rd_acc_cnt;
            fill_addr = 27'h43; req_index = 3'd7;
            push_fill(27'h43, 3'd7, 32'h1300, cyc + 17);
            fill_req = 1'b1;
            @(posedge clk); #1;
            fill_req = 1'b0;
            for (int i = 0; i < 40 && rd_acc_cnt < base + 4; i++) @(posedge clk);
            #1;
            check("reads_before_reset", LINE_W'(rd_acc_cnt - base), LINE_W'(4));
        end
        rst_n = 1'b0;
        exp_beats.delete();
        exp_commits.delete();
        exp_done.delete();
        @(posedge clk); #1;
        check("midrst_datain", arr_datain, '0);
        check("midrst_busy", LINE_W'(busy), '0);
        check("midrst_write_en", LINE_W'(arr_write_en), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        check("beats_left", LINE_W'(exp_beats.size()), '0);
        check("commits_left", LINE_W'(exp_commits.size()), '0);
        check("dones_left", LINE_W'(exp_done.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/line_fill_unit.md
# line_fill_unit

Memory-side line transfer engine for the multicycle OTTER L1 cache. On a miss, it can first write a dirty victim line back to main memory as 32-bit beats. It then fetches the replacement line as 32-bit beats, assembles it, and commits it to the cache data array in one full-mask write. It sits between the cache controller FSM and the data array's write port (`write_en`, `windex`, `datain`) on one side and the word-wide memory bus on the other.

## Interface
Parameters:
- `S_OFFSET`, 5, log2 bytes per line; must be ≥ 2. Line = 8·2^S_OFFSET bits. BEATS = 2^(S_OFFSET-2).
- `S_INDEX`, 3, log2 number of sets; width of the set index.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fill_req`  in  1  request a line fetch; sampled only in IDLE.
- `wb_req`  in  1  request a victim write-back; sampled only in IDLE.
- `req_index`  in  S_INDEX  destination set of the fill.
- `fill_addr`  in  32-S_OFFSET  line address to fetch.
- `wb_addr`  in  32-S_OFFSET  line address of the victim.
- `wb_line`  in  8·2^S_OFFSET  victim line data (the data array `dataout`).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  beat request valid.
- `mem_we`  out  1  1 = write beat, 0 = read beat.
- `mem_addr`  out  32  byte address of the beat.
- `mem_wdata`  out  32  write data.
- `mem_ready`  in  1  beat accepted when `mem_req & mem_ready`.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.
- `arr_write_en`  out  2^S_OFFSET  byte write mask to the data array.
- `arr_windex`  out  S_INDEX  array write index.
- `arr_datain`  out  8·2^S_OFFSET  assembled line.

## Operation
- **States:** IDLE, WB, FILL_REQ, FILL_WAIT, COMMIT, DONE.
- **IDLE:**
  - If `fill_req` or `wb_req` is high, capture all request inputs and both flags, and clear the beat counter.
  - Then go to WB if `wb_req`, else to FILL_REQ.
  - Requests arriving in any other state are ignored.
- **WB:**
  - Drive `mem_req=1`, `mem_we=1`, `mem_addr={wb_addr, beat, 2'b00}`, `mem_wdata=wb_line[32·beat +: 32]`.
  - On `mem_ready`, increment the beat counter.
  - After beat BEATS-1 is accepted, clear the counter, then go to FILL_REQ if the fill flag is set, else to DONE.
- **FILL_REQ:**
  - Drive `mem_req=1`, `mem_we=0`, `mem_addr={fill_addr, beat, 2'b00}`.
  - On `mem_ready`, go to FILL_WAIT.
- **FILL_WAIT:**
  - `mem_req=0`. At most one read is outstanding.
  - On `mem_rvalid`, store `mem_rdata` into line buffer word `beat` and increment the counter.
  - If the beat just stored is BEATS-1, go to COMMIT; else go to FILL_REQ.
- **COMMIT:** Drive `arr_write_en` all-ones and `arr_windex` = captured index for exactly this cycle. Go to DONE.
- **DONE:** `done=1`, `busy=1`. Go to IDLE.
- **Beat order:** beat 0 = line bits [31:0], at the lowest address. Addresses ascend and the low 2 bits are always 0.
- **Line buffer:** `arr_datain` always shows the line buffer. `arr_write_en` is 0 outside COMMIT.
- **Spurious input:** `mem_rvalid` outside FILL_WAIT is ignored, and `mem_rdata` is then not stored.

## Timing
- **Reset values:** while `rst_n=0` at an edge, every output goes to 0. That covers `busy`, `done`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `arr_write_en`, `arr_windex`, `arr_datain`. The state goes to IDLE and the counter and line buffer clear.
- **Reset mid-transfer:** abandons the transfer. No array write and no `done` follow.
- **All outputs are registered-state decodes.** No output depends combinationally on `mem_ready`, `mem_rvalid` or the request inputs.
- **Fill-only latency,** with `mem_ready=1` held and `rvalid` 1 cycle after acceptance: accept at cycle 0, 2·BEATS cycles of beats, COMMIT at cycle 2·BEATS+1, `done` at 2·BEATS+2. For S_OFFSET=5 this is COMMIT at 17 and `done` at 18.
- **Write-back-only latency,** with `mem_ready=1`: BEATS write cycles, then DONE. For S_OFFSET=5, `done` comes at cycle 9.
- **Stalls:** `mem_ready` low holds `mem_req` and `mem_addr`/`mem_wdata` stable. Arbitrary `rvalid` delay holds FILL_WAIT.
- **Back-to-back:** a new request is accepted in the first IDLE cycle after DONE.

## Test plan
- **Reset:** assert `rst_n=0` with `fill_req=1` → all outputs stay 0. After release, the request is accepted on the first edge.
- **Fill only, no stalls:** `fill_req`, `fill_addr=0x0000040`, index 5, memory returns 0x1000+beat.
  - `mem_addr` sequence is 0x800, 0x804 … 0x81C.
  - COMMIT at cycle 17 with `arr_write_en=32'hFFFF_FFFF`, `arr_windex=5`, word k = 0x1000+k.
  - `done` pulses at 18.
- **Evict-then-fill:** `wb_req`+`fill_req`, `wb_addr=0x1`, `wb_line` words 0xA0..0xA7.
  - Eight write beats to 0x20..0x3C carry 0xA0..0xA7, then the fill proceeds.
  - `arr_write_en` stays 0 until COMMIT.
- **Stalls:** `mem_ready` toggles 0/1 and `rvalid` delays 0–3 cycles.
  - `mem_addr`/`mem_wdata` are stable while stalled.
  - The committed line is identical to the no-stall case.
- **Spurious and ignored inputs:** `mem_rvalid` pulse in IDLE/WB and a new `fill_req` while `busy` → no capture and no extra transfer.
- **Reset mid-fill:** reset at beat 4 → no COMMIT and no `done`. `arr_datain` returns to 0.
